div_seq_signed: RTL and testbench

Parametrised iterative restoring divider that is the next generation of the team's 8-bit unsigned shift-subtract divider. It adds a configurable width W, per-operation signed/unsigned mode, divide-by-zero detection and signed-overflow flagging. It also keeps a fixed, data-independent latency. It sits behind any FSMD datapath that needs a quotient and remainder, and uses the same start / ready / done_tick handshake.

---
 rtl/div_seq_signed.sv | 227 ++++++++++++++++++++++
 tb/tb_div_seq_signed.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_signed.sv
// -----------------------------------------------------------------------------
// div_seq_signed
//
// Iterative restoring divider with fixed, data-independent latency.
// Computes quo = dvnd / dvsr and rmd = dvnd % dvsr on W-bit operands.
// In signed mode the quotient truncates toward zero and the remainder takes
// the sign of the dividend.
//
// Optional feature macro: DIV_SIGNED_EN
//   defined   : signed path compiled in (magnitude conversion, sign
//               correction in the fix state, ovf flag).
//   undefined : signed_op is ignored, ovf is tied to 0, and the fix state
//               is a pass-through, so latency does not change.
//
// Handshake: ready is high only in idle. A start seen on a rising edge
// while ready=1 is accepted and its operands are latched. A start while
// ready=0 is ignored and is not queued. done_tick pulses for exactly one
// cycle when quo/rmd/div0/ovf are final. These outputs hold until the
// next accepted start.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   operation request, sampled while ready=1
//   signed_op  in   1 = two's-complement operation, 0 = unsigned
//   dvnd       in   W-bit dividend
//   dvsr       in   W-bit divisor
//   ready      out  idle indicator
//   done_tick  out  one-cycle completion pulse
//   quo        out  W-bit quotient
//   rmd        out  W-bit remainder
//   div0       out  divisor was zero
//   ovf        out  signed overflow (MIN / -1)
//   dbg_state  out  current FSM state encoding (observation only)
//
// Latency from the accepting edge E0:
//   - done_tick is high E(W+1)..E(W+2).
//   - A zero divisor goes straight to done, so done_tick is high E0..E1.
// -----------------------------------------------------------------------------
module div_seq_signed #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic         signed_op,
   input  logic [W-1:0] dvnd,
   input  logic [W-1:0] dvsr,
   output logic         ready,
   output logic         done_tick,
   output logic [W-1:0] quo,
   output logic [W-1:0] rmd,
   output logic         div0,
   output logic         ovf,
   output logic [2:0]   dbg_state
);

   localparam int CBIT = $clog2(W) + 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_OP   = 3'd1,
      S_LAST = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    rh_q, rh_d;      // partial remainder
   logic [W-1:0]    rl_q, rl_d;      // remaining dividend bits / quotient bits
   logic [W-1:0]    d_q, d_d;        // divisor magnitude
   logic [CBIT-1:0] cnt_q, cnt_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rmd_q, neg_rmd_d;
   logic [W-1:0]    quo_q, quo_d;
   logic [W-1:0]    rmd_q, rmd_d;
   logic            div0_q, div0_d;
   logic            ovf_q, ovf_d;

   // Operand sign and magnitude. |MIN| = 2^(W-1) still fits unsigned in W bits.
   logic            sgn_a, sgn_b;
   logic [W-1:0]    mag_a, mag_b;

   // One restoring step
   logic            q_bit;
   logic [W-1:0]    rh_tmp;

`ifndef DIV_SIGNED_EN
   logic unused_signed_op;
   assign unused_signed_op = signed_op;
`endif

   always_comb begin
`ifdef DIV_SIGNED_EN
      sgn_a = signed_op & dvnd[W-1];
      sgn_b = signed_op & dvsr[W-1];
`else
      sgn_a = 1'b0;
      sgn_b = 1'b0;
`endif
      mag_a = sgn_a ? (~dvnd + 1'b1) : dvnd;
      mag_b = sgn_b ? (~dvsr + 1'b1) : dvsr;
   end

   always_comb begin
      q_bit  = (rh_q >= d_q);
      rh_tmp = q_bit ? (rh_q - d_q) : rh_q;
   end

   always_comb begin
      state_d   = state_q;
      rh_d      = rh_q;
      rl_d      = rl_q;
      d_d       = d_q;
      cnt_d     = cnt_q;
      neg_quo_d = neg_quo_q;
      neg_rmd_d = neg_rmd_q;
      quo_d     = quo_q;
      rmd_d     = rmd_q;
      div0_d    = div0_q;
      ovf_d     = ovf_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               div0_d    = 1'b0;
               ovf_d     = 1'b0;
               neg_quo_d = sgn_a ^ sgn_b;
               neg_rmd_d = sgn_a;
               if (dvsr == '0) begin
                  div0_d  = 1'b1;
                  quo_d   = '1;
                  rmd_d   = dvnd;
                  state_d = S_DONE;
               end else begin
                  // The dividend MSB is pre-shifted into rh. The first
                  // iteration then compares a real bit, and W steps cover
                  // the whole dividend.
                  rh_d    = {{(W-1){1'b0}}, mag_a[W-1]};
                  rl_d    = {mag_a[W-2:0], 1'b0};
                  d_d     = mag_b;
                  cnt_d   = CBIT'(W);
                  state_d = S_OP;
               end
            end
         end

         S_OP: begin
            rl_d  = {rl_q[W-2:0], q_bit};
            rh_d  = {rh_tmp[W-2:0], rl_q[W-1]};
            cnt_d = cnt_q - 1'b1;
            if (cnt_d == CBIT'(1)) begin
               state_d = S_LAST;
            end
         end

         S_LAST: begin
            // No shift of rh here, so it is left holding the true remainder.
            rl_d    = {rl_q[W-2:0], q_bit};
            rh_d    = rh_tmp;
            state_d = S_FIX;
         end

         S_FIX: begin
            quo_d = rl_q;
            rmd_d = rh_q;
`ifdef DIV_SIGNED_EN
            if (neg_quo_q) begin
               quo_d = ~rl_q + 1'b1;
            end
            if (neg_rmd_q) begin
               rmd_d = ~rh_q + 1'b1;
            end
            // Both operands negative and the quotient magnitude is 2^(W-1).
            // This is only possible for MIN / -1.
            ovf_d = neg_rmd_q & ~neg_quo_q & rl_q[W-1];
`endif
            state_d = S_DONE;
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         rh_q      <= '0;
         rl_q      <= '0;
         d_q       <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rmd_q <= 1'b0;
         quo_q     <= '0;
         rmd_q     <= '0;
         div0_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rh_q      <= rh_d;
         rl_q      <= rl_d;
         d_q       <= d_d;
         cnt_q     <= cnt_d;
         neg_quo_q <= neg_quo_d;
         neg_rmd_q <= neg_rmd_d;
         quo_q     <= quo_d;
         rmd_q     <= rmd_d;
         div0_q    <= div0_d;
         ovf_q     <= ovf_d;
      end
   end

   assign ready     = (state_q == S_IDLE);
   assign done_tick = (state_q == S_DONE);
   assign quo       = quo_q;
   assign rmd       = rmd_q;
   assign div0      = div0_q;
   assign ovf       = ovf_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_div_seq_signed.sv
module tb_div_seq_signed;

`ifdef DIV_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   // ---------------- W=8 instance ----------------
   logic       start8, sgn8;
   logic [7:0] a8, b8, quo8, rmd8;
   logic       ready8, done8, div08, ovf8;
   logic [2:0] st8;

   div_seq_signed #(.W(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .start(start8), .signed_op(sgn8),
      .dvnd(a8), .dvsr(b8), .ready(ready8), .done_tick(done8),
      .quo(quo8), .rmd(rmd8), .div0(div08), .ovf(ovf8), .dbg_state(st8)
   );

   // ---------------- W=16 instance ----------------
   logic        start16, sgn16;
   logic [15:0] a16, b16, quo16, rmd16;
   logic        ready16, done16, div016, ovf16;
   logic [2:0]  st16;

   div_seq_signed #(.W(16)) dut16 (
      .clk(clk), .reset_n(reset_n), .start(start16), .signed_op(sgn16),
      .dvnd(a16), .dvsr(b16), .ready(ready16), .done_tick(done16),
      .quo(quo16), .rmd(rmd16), .div0(div016), .ovf(ovf16), .dbg_state(st16)
   );

   // ---------------- scoreboard counters ----------------
   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model (plain integer arithmetic) ----------------
   function automatic void ref_div(input int w, input bit sgn, input longint a, input longint b,
                                   output longint q, output longint r,
                                   output bit d0, output bit ov);
      longint full, half, mask, sa, sb;
      full = 64'sd1 <<< w;
      half = 64'sd1 <<< (w - 1);
      mask = full - 1;
      d0 = 1'b0;
      ov = 1'b0;
      if (b == 0) begin
         d0 = 1'b1;
         q  = mask;
         r  = a;
      end else if (sgn && SIGNED_EN) begin
         sa = (a >= half) ? a - full : a;
         sb = (b >= half) ? b - full : b;
         q  = (sa / sb) & mask;
         r  = (sa % sb) & mask;
         ov = (sa == -half) && (sb == -1);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // ---------------- driver: one W=8 operation ----------------
   // mode 1 pulses a stray start while busy, sampled at E3.
   task automatic op8(input bit sgn, input logic [7:0] a, input logic [7:0] b, input int mode);
      longint eq, er;
      bit     ed0, eov;
      int     cyc, exp_lat;
      ref_div(8, sgn, longint'(a), longint'(b), eq, er, ed0, eov);
      exp_lat = ed0 ? 0 : 9;
      @(negedge clk);
      start8 = 1'b1; sgn8 = sgn; a8 = a; b8 = b;
      @(posedge clk); #1;
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
      chk("busy_ready8", {31'd0, ready8}, 32'd0);
      cyc = 0;
      while (done8 !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (mode == 1) start8 = (cyc == 2);
      end
      start8 = 1'b0;
      chk("latency8", 32'(cyc), 32'(exp_lat));
      chk("quo8", {24'd0, quo8}, 32'(eq));
      chk("rmd8", {24'd0, rmd8}, 32'(er));
      chk("div0_8", {31'd0, div08}, {31'd0, ed0});
      chk("ovf8", {31'd0, ovf8}, {31'd0, eov});
      @(posedge clk); #1;
      chk("done_pulse8", {31'd0, done8}, 32'd0);
      chk("ready_back8", {31'd0, ready8}, 32'd1);
   endtask

   // ---------------- driver: one W=16 operation ----------------
   task automatic op16(input bit sgn, input logic [15:0] a, input logic [15:0] b);
      longint eq, er;
      bit     ed0, eov;
      int     cyc, exp_lat;
      ref_div(16, sgn, longint'(a), longint'(b), eq, er, ed0, eov);
      exp_lat = ed0 ? 0 : 17;
      @(negedge clk);
      start16 = 1'b1; sgn16 = sgn; a16 = a; b16 = b;
      @(posedge clk); #1;
      start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
      cyc = 0;
      while (done16 !== 1'b1 && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("latency16", 32'(cyc), 32'(exp_lat));
      chk("quo16", {16'd0, quo16}, 32'(eq));
      chk("rmd16", {16'd0, rmd16}, 32'(er));
      chk("div0_16", {31'd0, div016}, {31'd0, ed0});
      chk("ovf16", {31'd0, ovf16}, {31'd0, eov});
      @(posedge clk); #1;
      chk("done_pulse16", {31'd0, done16}, 32'd0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin : main
      int n_done;
      int sel;
      logic [7:0]  ra, rb;
      logic [15:0] wa, wb;

      reset_n = 1'b0;
      start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
      start16 = 1'b0; sgn16 = 1'b0; a16 = '0; b16 = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, ready8}, 32'd1);
      chk("rst_done", {31'd0, done8}, 32'd0);
      chk("rst_quo", {24'd0, quo8}, 32'd0);
      chk("rst_rmd", {24'd0, rmd8}, 32'd0);
      chk("rst_div0", {31'd0, div08}, 32'd0);
      chk("rst_ovf", {31'd0, ovf8}, 32'd0);
      chk("rst_quo16", {16'd0, quo16}, 32'd0);
      #1 reset_n = 1'b1;

      // Start is raised before the first rising edge after release.
      op8(1'b0, 8'd100, 8'd7, 0);
      op8(1'b1, 8'hF9, 8'h02, 0);
      op8(1'b0, 8'hF9, 8'h02, 0);
      op8(1'b0, 8'h05, 8'h00, 0);
      op8(1'b1, 8'h05, 8'h00, 0);
      op8(1'b0, 8'd9, 8'd3, 0);
      op8(1'b1, 8'h80, 8'hFF, 0);
      op8(1'b1, 8'h80, 8'h01, 0);
      op8(1'b1, 8'h7F, 8'h80, 0);
      op8(1'b0, 8'hFF, 8'hFF, 0);
      op8(1'b0, 8'd200, 8'd13, 1);

      // Abort mid-operation with reset.
      @(negedge clk);
      start8 = 1'b1; sgn8 = 1'b0; a8 = 8'd100; b8 = 8'd7;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_ready", {31'd0, ready8}, 32'd1);
      chk("abort_quo", {24'd0, quo8}, 32'd0);
      chk("abort_rmd", {24'd0, rmd8}, 32'd0);
      chk("abort_done", {31'd0, done8}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      n_done = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done8 === 1'b1) n_done++;
      end
      chk("abort_no_done", 32'(n_done), 32'd0);

      // W=16 directed
      op16(1'b0, 16'd50000, 16'd123);
      op16(1'b1, 16'h8000, 16'hFFFF);
      op16(1'b1, 16'hFF85, 16'd10);

      // Random W=8, with zero divisors and MIN/-1 mixed in.
      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 9);
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         if (sel == 0) rb = 8'h00;
         if (sel == 1) begin ra = 8'h80; rb = 8'hFF; end
         op8(1'($urandom), ra, rb, 0);
      end

      // Random W=16
      for (int i = 0; i < 10; i++) begin
         wa = 16'($urandom);
         wb = 16'($urandom_range(0, 65535));
         if (i == 3) wb = 16'h0000;
         op16(1'($urandom), wa, wb);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
